// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer block: reads are combinational; writes commit on t_cycle==3.
// TIMA overflow reads 00 for four clocks, then reloads from TMA and pulses irq_timer for one clock.
module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_hit,
  output logic        irq_timer
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OVF  = 1'b1;

  logic [15:0] counter;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic [0:0]  state;
  logic [1:0]  delay;
  logic        sig;
  logic        sig_q;
  logic        tick;
  logic        tap;
  logic [15:0] offset;
  logic        commit;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;

  // Modular subtraction keeps the range check correct even when BASE_ADDR sits near FFFF.
  assign offset  = mem_addr - BASE_ADDR;
  assign mem_hit = (offset < 16'd4);

  always_comb begin
    mem_data_out = 8'hFF;
    if (mem_hit) begin
      case (offset[1:0])
        2'd0:    mem_data_out = counter[15:8];
        2'd1:    mem_data_out = tima;
        2'd2:    mem_data_out = tma;
        default: mem_data_out = {5'b11111, tac};
      endcase
    end
  end

  assign commit  = mem_enable & mem_write & mem_hit & (t_cycle == 2'd3);
  assign wr_div  = commit & (offset[1:0] == 2'd0);
  assign wr_tima = commit & (offset[1:0] == 2'd1);
  assign wr_tma  = commit & (offset[1:0] == 2'd2);
  assign wr_tac  = commit & (offset[1:0] == 2'd3);

  always_comb begin
    case (tac[1:0])
      2'b00:   tap = counter[9];
      2'b01:   tap = counter[3];
      2'b10:   tap = counter[5];
      default: tap = counter[7];
    endcase
  end

  // Falling-edge detect on the gated tap; DIV clears and TAC changes can fire it too.
  assign sig  = tac[2] & tap;
  assign tick = sig_q & ~sig;

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= 16'h0000;
      sig_q   <= 1'b0;
      tma     <= 8'h00;
      tac     <= 3'b000;
    end else begin
      counter <= wr_div ? 16'h0000 : counter + 16'd1;
      sig_q   <= sig;
      if (wr_tma) tma <= mem_data_in;
      if (wr_tac) tac <= mem_data_in[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      delay     <= 2'd0;
      tima      <= 8'h00;
      irq_timer <= 1'b0;
    end else begin
      irq_timer <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_tima) begin
            tima <= mem_data_in;
          end else if (tick) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= OVF;
              delay <= 2'd0;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        OVF: begin
          // The reload edge outranks a TIMA write but picks up a same-edge TMA write.
          if (delay == 2'd3) begin
            tima      <= wr_tma ? mem_data_in : tma;
            irq_timer <= 1'b1;
            state     <= IDLE;
            delay     <= 2'd0;
          end else if (wr_tima) begin
            tima  <= mem_data_in;
            state <= IDLE;
            delay <= 2'd0;
          end else begin
            delay <= delay + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer.sv
// Randomized and directed bench for timer: a reference model predicts every cycle's bus read and irq,
// a monitor compares them against the DUT half a clock later.
module tb_timer;

  localparam logic [15:0] BASE = 16'hFF04;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  t_cycle;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_write;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        mem_hit;
  logic        irq_timer;

  always #5 clk = ~clk;

  timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .t_cycle(t_cycle),
    .mem_addr(mem_addr),
    .mem_enable(mem_enable),
    .mem_write(mem_write),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_hit(mem_hit),
    .irq_timer(irq_timer)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  logic prev_irq = 1'b0;

  // Reference model: counter value, registers, overflow bookkeeping in edges since overflow.
  logic [15:0] m_cnt;
  logic [7:0]  m_tima;
  logic [7:0]  m_tma;
  logic [2:0]  m_tac;
  logic        m_prev;
  logic        m_ovf;
  logic        m_irq;
  int          m_edges;

  task automatic check(input string name, input logic [15:0] addr,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s addr=%h t=%0t got=%h expected=%h", name, addr, $time, act, exp);
  endtask

  function automatic logic m_sig();
    int idx;
    case (m_tac[1:0])
      2'b00:   idx = 9;
      2'b01:   idx = 3;
      2'b10:   idx = 5;
      default: idx = 7;
    endcase
    return m_tac[2] && m_cnt[idx];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [15:0] off;
    off    = mem_addr - BASE;
    e.addr = mem_addr;
    e.hit  = (off < 16'd4);
    e.irq  = m_irq;
    if (!e.hit)           e.dout = 8'hFF;
    else if (off == 16'd0) e.dout = m_cnt[15:8];
    else if (off == 16'd1) e.dout = m_tima;
    else if (off == 16'd2) e.dout = m_tma;
    else                   e.dout = {5'b11111, m_tac};
    return e;
  endfunction

  task automatic model_edge();
    logic [15:0] off;
    logic commit, sig, tick;
    if (reset) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_prev = 0; m_ovf = 0; m_irq = 0; m_edges = 0;
      return;
    end
    off    = mem_addr - BASE;
    commit = mem_enable && mem_write && (off < 16'd4) && (t_cycle == 2'd3);
    sig    = m_sig();
    tick   = m_prev && !sig;
    m_irq  = 0;
    if (m_ovf) begin
      m_edges++;
      if (m_edges == 4) begin
        m_tima = (commit && off == 16'd2) ? mem_data_in : m_tma;
        m_irq  = 1;
        m_ovf  = 0;
      end else if (commit && off == 16'd1) begin
        m_tima = mem_data_in;
        m_ovf  = 0;
      end
    end else if (commit && off == 16'd1) begin
      m_tima = mem_data_in;
    end else if (tick) begin
      if (m_tima == 8'hFF) begin
        m_tima = 0; m_ovf = 1; m_edges = 0;
      end else begin
        m_tima = m_tima + 8'd1;
      end
    end
    if (commit && off == 16'd2) m_tma = mem_data_in;
    if (commit && off == 16'd3) m_tac = mem_data_in[2:0];
    m_prev = sig;
    m_cnt  = (commit && off == 16'd0) ? 16'h0000 : m_cnt + 16'd1;
  endtask

  // One clock of stimulus, entered just after a rising edge.
  task automatic cyc(input logic rst, input logic [15:0] a, input logic en, input logic wr,
                     input logic [7:0] d, input logic [1:0] t);
    reset = rst; mem_addr = a; mem_enable = en; mem_write = wr; mem_data_in = d; t_cycle = t;
    q.push_back(model_out());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic [15:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 1'b1, 1'b0, 8'h00, 2'd3);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    cyc(1'b0, BASE + {14'd0, off}, 1'b1, 1'b1, d, 2'd3);
  endtask

  task automatic wait_ovf();
    for (int i = 0; i < 3000 && !m_ovf; i++) idle(1, BASE + 16'd1);
  endtask

  task automatic wait_bit3();
    for (int i = 0; i < 40 && !m_cnt[3]; i++) idle(1, BASE + 16'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rdata", e.addr, {8'h00, mem_data_out}, {8'h00, e.dout});
      check("hit",   e.addr, {15'd0, mem_hit},      {15'd0, e.hit});
      check("irq",   e.addr, {15'd0, irq_timer},    {15'd0, e.irq});
      check("irq_double", e.addr, {15'd0, irq_timer && prev_irq}, 16'd0);
    end
    prev_irq = irq_timer;
  end

  initial begin
    reset = 1'b1; mem_addr = BASE; mem_enable = 1'b0; mem_write = 1'b0;
    mem_data_in = 8'h00; t_cycle = 2'd0;
    @(posedge clk);
    model_edge();
    #1;
    cyc(1'b1, BASE, 1'b0, 1'b0, 8'h00, 2'd0);
    for (int i = 0; i < 4; i++) idle(1, BASE + 16'(i));

    // DIV rate and DIV clear
    idle(252, BASE);
    idle(4, BASE);
    wr(2'd0, 8'h5A);
    idle(3, BASE);

    // TIMA rates at TAC=05 and TAC=04
    wr(2'd3, 8'h05); wr(2'd1, 8'h00);
    idle(70, BASE + 16'd1);
    wr(2'd3, 8'h04); wr(2'd1, 8'h00);
    idle(2100, BASE + 16'd1);

    // Overflow, reload and irq
    wr(2'd2, 8'hAB); wr(2'd3, 8'h05); wr(2'd1, 8'hFF);
    idle(40, BASE + 16'd1);

    // Cancel by TIMA write two clocks after overflow
    wr(2'd1, 8'hFF); wait_ovf(); idle(1, BASE + 16'd1);
    wr(2'd1, 8'h42); idle(30, BASE + 16'd1);

    // TIMA write on the reload edge is ignored
    wr(2'd1, 8'hFF); wait_ovf(); idle(3, BASE + 16'd1);
    wr(2'd1, 8'h77); idle(6, BASE + 16'd1);

    // TMA write on the reload edge is the reloaded value
    wr(2'd1, 8'hFF); wait_ovf(); idle(3, BASE + 16'd1);
    wr(2'd2, 8'h5C); idle(6, BASE + 16'd1);

    // DIV write glitch with the timer enabled, then with it disabled
    wr(2'd1, 8'h10); wr(2'd3, 8'h05); wait_bit3();
    wr(2'd0, 8'h00); idle(4, BASE + 16'd1);
    wr(2'd3, 8'h01); wait_bit3();
    wr(2'd0, 8'h00); idle(4, BASE + 16'd1);

    // Reset in the middle of an overflow
    wr(2'd3, 8'h05); wr(2'd2, 8'hAB); wr(2'd1, 8'hFF); wait_ovf(); idle(1, BASE + 16'd1);
    cyc(1'b1, BASE + 16'd1, 1'b1, 1'b1, 8'h99, 2'd3);
    for (int i = 0; i < 5; i++) idle(1, BASE + 16'(i));
    idle(8, BASE + 16'd1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic [1:0]  t;
      logic        w, en, rst;
      a   = BASE - 16'd2 + 16'($urandom_range(0, 7));
      w   = ($urandom_range(0, 99) < 15);
      en  = ($urandom_range(0, 3) != 0);
      t   = ($urandom_range(0, 9) < 7) ? 2'd3 : 2'($urandom_range(0, 2));
      d   = 8'($urandom_range(0, 255));
      if (a == BASE + 16'd1 && $urandom_range(0, 1) == 1) d = 8'hFC + 8'($urandom_range(0, 3));
      if (a == BASE + 16'd3 && $urandom_range(0, 1) == 1) d = 8'h05;
      rst = ($urandom_range(0, 599) == 0);
      cyc(rst, a, en, w, d, t);
    end

    idle(2, BASE + 16'd1);
    @(negedge clk);
    #1;
    check("drain", 16'h0000, 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
